forw_park_module: RTL and testbench

- Forward Park transformation stage, placed directly downstream of the forward Clarke stage.
- Consumes alpha/beta samples plus rotor-angle sine/cosine and produces d/q components:
  - d = al*cos + be*sin
  - q = be*cos - al*sin
- Uses one shared signed multiplier, time-multiplexed by a small FSM, with valid/ready handshaking on input and a valid pulse on output.

---
 rtl/forw_park_module.sv | 253 +++++++++++++++++++++++++
 tb/tb_forw_park_module.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/forw_park_module.sv
// -----------------------------------------------------------------------------
// forw_park_module
//
// Forward Park transformation stage. It sits directly after the forward Clarke
// stage and rotates the stationary alpha/beta frame into the rotor d/q frame:
//
//     d = al*cos + be*sin
//     q = be*cos - al*sin
//
// A single signed multiplier is shared over four cycles by a small FSM:
//
//     IDLE -> MUL0 (acc_d  = al*cos)
//          -> MUL1 (acc_d += be*sin)
//          -> MUL2 (acc_q  = be*cos)
//          -> MUL3 (acc_q - al*sin formed combinationally, results registered)
//          -> IDLE
//
// A sample accepted at edge T0 produces valid_o for one cycle after edge T4.
// ready_o is high again in that same cycle, so the next sample can be taken
// at edge T5, giving one result every five cycles.
//
// Ports:
//   clk_i    : system clock, rising edge active
//   rst_i    : asynchronous active-high reset
//   al_i     : signed alpha component, Q1.(DATA_WIDTH-1)
//   be_i     : signed beta component,  Q1.(DATA_WIDTH-1)
//   sin_i    : signed sin(theta),      Q1.(DATA_WIDTH-1)
//   cos_i    : signed cos(theta),      Q1.(DATA_WIDTH-1)
//   valid_i  : input sample valid
//   ready_o  : block can accept a sample (IDLE and not in reset)
//   d_o      : signed d component, held until the next valid_o
//   q_o      : signed q component, held until the next valid_o
//   valid_o  : one-cycle pulse when d_o/q_o/sat_o are updated
//   sat_o    : d or q of the current result was clamped; qualified by valid_o
// -----------------------------------------------------------------------------
module forw_park_module #(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] al_i,
    input  logic [DATA_WIDTH-1:0] be_i,
    input  logic [DATA_WIDTH-1:0] sin_i,
    input  logic [DATA_WIDTH-1:0] cos_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] d_o,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic                  valid_o,
    output logic                  sat_o
);

    // Product width of two W-bit signed operands, and accumulator width with
    // one guard bit so the sum of two full-scale products cannot overflow.
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = 2 * DATA_WIDTH + 1;

    // Clamp bounds expressed at accumulator width so the comparison happens
    // on the full scaled value, before any bits are discarded.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        $signed({{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}});

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        MUL3 = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Captured sample; the inputs are free to change once accepted.
    logic signed [DATA_WIDTH-1:0] al_reg;
    logic signed [DATA_WIDTH-1:0] be_reg;
    logic signed [DATA_WIDTH-1:0] sin_reg;
    logic signed [DATA_WIDTH-1:0] cos_reg;

    logic signed [ACC_W-1:0] acc_d_reg;
    logic signed [ACC_W-1:0] acc_q_reg;
    logic signed [ACC_W-1:0] acc_q_final;

    logic [DATA_WIDTH-1:0] d_reg;
    logic [DATA_WIDTH-1:0] q_reg;
    logic                  valid_reg;
    logic                  sat_reg;

    logic accept;

    // Shared multiplier: operands selected by the current state.
    logic signed [DATA_WIDTH-1:0] mul_a;
    logic signed [DATA_WIDTH-1:0] mul_b;
    logic signed [PROD_W-1:0]     mul_a_ext;
    logic signed [PROD_W-1:0]     mul_b_ext;
    logic signed [PROD_W-1:0]     mul_p;
    logic signed [ACC_W-1:0]      mul_p_ext;

    // Per-lane scaling/saturation (lane 0 = d, lane 1 = q).
    logic signed [ACC_W-1:0]      lane_acc [2];
    logic        [DATA_WIDTH-1:0] lane_res [2];
    logic        [1:0]            lane_sat;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign ready_o = (state_reg == IDLE) && !rst_i;
    assign accept  = valid_i && (state_reg == IDLE);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = MUL0;
            MUL0:    state_next = MUL1;
            MUL1:    state_next = MUL2;
            MUL2:    state_next = MUL3;
            MUL3:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand selection for the shared multiplier
    // -------------------------------------------------------------------------
    always_comb begin
        mul_a = al_reg;
        mul_b = cos_reg;
        case (state_reg)
            MUL1: begin
                mul_a = be_reg;
                mul_b = sin_reg;
            end
            MUL2: begin
                mul_a = be_reg;
                mul_b = cos_reg;
            end
            MUL3: begin
                mul_a = al_reg;
                mul_b = sin_reg;
            end
            default: begin
                mul_a = al_reg;
                mul_b = cos_reg;
            end
        endcase
    end

    // Sign-extend explicitly so the product is computed at full width.
    assign mul_a_ext = {{DATA_WIDTH{mul_a[DATA_WIDTH-1]}}, mul_a};
    assign mul_b_ext = {{DATA_WIDTH{mul_b[DATA_WIDTH-1]}}, mul_b};
    assign mul_p     = mul_a_ext * mul_b_ext;
    assign mul_p_ext = {mul_p[PROD_W-1], mul_p};

    // The final q subtraction happens in the same cycle as the last product so
    // the result can be registered at the MUL3 edge without an extra state.
    assign acc_q_final = acc_q_reg - mul_p_ext;

    // -------------------------------------------------------------------------
    // Scaling and saturation, one instance per output lane
    // -------------------------------------------------------------------------
    assign lane_acc[0] = acc_d_reg;
    assign lane_acc[1] = acc_q_final;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic signed [ACC_W-1:0] shifted;

            // Arithmetic shift = floor division by 2**(DATA_WIDTH-1).
            assign shifted = lane_acc[gi] >>> (DATA_WIDTH - 1);

            assign lane_sat[gi] = (shifted > SAT_MAX) || (shifted < SAT_MIN);

            assign lane_res[gi] = (shifted > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] :
                                  (shifted < SAT_MIN) ? SAT_MIN[DATA_WIDTH-1:0] :
                                                        shifted[DATA_WIDTH-1:0];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Input capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            al_reg  <= '0;
            be_reg  <= '0;
            sin_reg <= '0;
            cos_reg <= '0;
        end else if (accept) begin
            al_reg  <= $signed(al_i);
            be_reg  <= $signed(be_i);
            sin_reg <= $signed(sin_i);
            cos_reg <= $signed(cos_i);
        end
    end

    // -------------------------------------------------------------------------
    // Accumulators
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_d_reg <= '0;
            acc_q_reg <= '0;
        end else begin
            case (state_reg)
                MUL0:    acc_d_reg <= mul_p_ext;
                MUL1:    acc_d_reg <= acc_d_reg + mul_p_ext;
                MUL2:    acc_q_reg <= mul_p_ext;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output registers: updated only at the MUL3 edge, held otherwise
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_reg     <= '0;
            q_reg     <= '0;
            sat_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= (state_reg == MUL3);
            if (state_reg == MUL3) begin
                d_reg   <= lane_res[0];
                q_reg   <= lane_res[1];
                sat_reg <= |lane_sat;
            end
        end
    end

    assign d_o     = d_reg;
    assign q_o     = q_reg;
    assign valid_o = valid_reg;
    assign sat_o   = sat_reg;

endmodule

// File: tb/tb_forw_park_module.sv
// -----------------------------------------------------------------------------
// tb_forw_park_module
//
// Self-checking bench for forw_park_module. A behavioural model computes d/q
// from the textbook formulas with integer arithmetic (floor division and
// clamping) and tracks acceptance with a simple busy countdown.
// -----------------------------------------------------------------------------
module tb_forw_park_module;

    localparam int W    = 10;
    localparam int DIV  = 2 ** (W - 1);
    localparam int FMAX = DIV - 1;
    localparam int FMIN = -DIV;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [W-1:0] al_i  = '0;
    logic [W-1:0] be_i  = '0;
    logic [W-1:0] sin_i = '0;
    logic [W-1:0] cos_i = '0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] d_o;
    logic [W-1:0] q_o;
    logic         valid_o;
    logic         sat_o;

    forw_park_module #(.DATA_WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .al_i    (al_i),
        .be_i    (be_i),
        .sin_i   (sin_i),
        .cos_i   (cos_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .d_o     (d_o),
        .q_o     (q_o),
        .valid_o (valid_o),
        .sat_o   (sat_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Model state
    int busy      = 0;    // cycles until the in-flight result appears
    int pend_d    = 0;
    int pend_q    = 0;
    int pend_sat  = 0;
    int last_d    = 0;
    int last_q    = 0;
    int last_sat  = 0;
    int exp_valid = 0;
    int results   = 0;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint x);
        longint r;
        r = x / DIV;
        if (x < 0 && (x % DIV) != 0) r = r - 1;
        return r;
    endfunction

    function automatic int clamp(input longint x, output int was_sat);
        was_sat = 0;
        if (x > FMAX) begin
            was_sat = 1;
            return FMAX;
        end
        if (x < FMIN) begin
            was_sat = 1;
            return FMIN;
        end
        return int'(x);
    endfunction

    task automatic park_model(input int al, input int be, input int s, input int c);
        longint d_full;
        longint q_full;
        int sd;
        int sq;
        d_full   = longint'(al) * c + longint'(be) * s;
        q_full   = longint'(be) * c - longint'(al) * s;
        pend_d   = clamp(floor_div(d_full), sd);
        pend_q   = clamp(floor_div(q_full), sq);
        pend_sat = (sd != 0 || sq != 0) ? 1 : 0;
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, check #1 after.
    task automatic cycle(input bit v, input int al, input int be, input int s, input int c);
        valid_i = v;
        al_i  = al[W-1:0];
        be_i  = be[W-1:0];
        sin_i = s[W-1:0];
        cos_i = c[W-1:0];
        @(posedge clk_i);
        exp_valid = 0;
        if (busy == 0 && v) begin
            park_model(al, be, s, c);
            busy = 4;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                exp_valid = 1;
                last_d    = pend_d;
                last_q    = pend_q;
                last_sat  = pend_sat;
            end
        end
        #1;
        check_val("ready", ready_o, (busy == 0) ? 1 : 0);
        check_val("valid", valid_o, exp_valid);
        check_val("d", $signed(d_o), last_d);
        check_val("q", $signed(q_o), last_q);
        check_val("sat", sat_o, last_sat);
        if (valid_o === 1'b1) results++;
        if (exp_valid != 0)
            $display("result d=%0d q=%0d sat=%0d (exp d=%0d q=%0d sat=%0d)",
                     $signed(d_o), $signed(q_o), sat_o, last_d, last_q, last_sat);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(0, 2 * DIV - 1)) - DIV;
    endfunction

    task automatic reset_model();
        busy = 0; exp_valid = 0;
        last_d = 0; last_q = 0; last_sat = 0;
    endtask

    initial begin
        int cnt0;

        // Reset state while rst_i is high
        #2;
        check_val("rst_ready", ready_o, 0);
        check_val("rst_valid", valid_o, 0);
        check_val("rst_d", $signed(d_o), 0);
        check_val("rst_q", $signed(q_o), 0);
        check_val("rst_sat", sat_o, 0);
        #10 rst_i = 1'b0;   // released between edges (t=12)
        #1;
        check_val("post_rst_ready", ready_o, 1);
        reset_model();

        // 1: pure cos rotation
        cycle(1, 200, -100, 0, 511);
        idle(5);
        // 2: pure sin rotation
        cycle(1, 200, -100, 511, 0);
        idle(5);
        // 3: saturation in both directions
        cycle(1, 511, 511, 511, 511);
        idle(5);
        cycle(1, -512, -512, 511, 511);
        idle(5);

        // 4: valid_i held high with a fresh sample every cycle
        cnt0 = results;
        for (int i = 0; i < 20; i++) cycle(1, rnd_s(), rnd_s(), rnd_s(), rnd_s());
        check_val("hold_valid_results", results - cnt0, 4);
        idle(5);

        // 5: reset during MUL2
        cycle(1, 300, 250, 100, 400);
        idle(2);            // state is now MUL2
        #2 rst_i = 1'b1;    // asynchronous, away from the edge
        #1;
        check_val("mid_rst_ready", ready_o, 0);
        check_val("mid_rst_valid", valid_o, 0);
        check_val("mid_rst_d", $signed(d_o), 0);
        check_val("mid_rst_q", $signed(q_o), 0);
        check_val("mid_rst_sat", sat_o, 0);
        reset_model();
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        check_val("rel_ready", ready_o, 1);
        idle(6);            // no spurious valid_o
        cycle(1, -123, 321, -200, 450);
        idle(4);

        // 6: output hold over 10 idle cycles
        idle(10);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 2) != 0), rnd_s(), rnd_s(), rnd_s(), rnd_s());
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
